// File: rtl/fpu_mul_pkg.sv
// Shared types and widths for the sequential mantissa multiplier.
// The state type and the operand and product geometry live here.
package fpu_mul_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 48;
    localparam int BYTE_W = 8;
    localparam int NUM_PP = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mantissa_mul_seq_mult8.sv
// Combinational 8x8 unsigned multiplier.
// The top reuses one instance for every partial product.
module Multiplier_8X8
    import fpu_mul_pkg::*;
(
    input  logic [BYTE_W-1:0]   a_i,
    input  logic [BYTE_W-1:0]   b_i,
    output logic [2*BYTE_W-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/mantissa_mul_seq.sv
// Sequential 24x24 mantissa multiplier.
// It accumulates nine byte partial products through one shared 8x8 multiplier.
module mantissa_mul_seq
    import fpu_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] a_i,
    input  logic [MANT_W-1:0] b_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p_o,
    output logic              busy_o
);

    state_e              state_q, state_d;
    logic [1:0]          i_q, i_d;
    logic [1:0]          j_q, j_d;
    logic [MANT_W-1:0]   a_q, a_d;
    logic [MANT_W-1:0]   b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;

    logic [BYTE_W-1:0]   a_byte;
    logic [BYTE_W-1:0]   b_byte;
    logic [2*BYTE_W-1:0] pp;
    logic [2:0]          sh;
    logic [PROD_W-1:0]   pp_ext;
    logic [PROD_W-1:0]   pp_sh;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy_o    = (state_q == ST_MUL);
    assign p_o       = acc_q;

    // Pick byte i of A and byte j of B for the current partial product
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        unique case (i_q)
            2'd0:    a_byte = a_q[7:0];
            2'd1:    a_byte = a_q[15:8];
            2'd2:    a_byte = a_q[23:16];
            default: a_byte = '0;
        endcase
        unique case (j_q)
            2'd0:    b_byte = b_q[7:0];
            2'd1:    b_byte = b_q[15:8];
            2'd2:    b_byte = b_q[23:16];
            default: b_byte = '0;
        endcase
    end

    Multiplier_8X8 u_mult (
        .a_i (a_byte),
        .b_i (b_byte),
        .p_o (pp)
    );

    assign sh     = {1'b0, i_q} + {1'b0, j_q};
    assign pp_ext = {{(PROD_W-2*BYTE_W){1'b0}}, pp};

    // Align the partial product to byte position i+j
    always_comb begin
        pp_sh = '0;
        unique case (sh)
            3'd0:    pp_sh = pp_ext;
            3'd1:    pp_sh = pp_ext << 8;
            3'd2:    pp_sh = pp_ext << 16;
            3'd3:    pp_sh = pp_ext << 24;
            3'd4:    pp_sh = pp_ext << 32;
            default: pp_sh = '0;
        endcase
    end

    // Next-state logic: flush wins over accept and the output handshake
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        if (flush) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_d     = a_i;
                        b_d     = b_i;
                        acc_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        state_d = ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_d = acc_q + pp_sh;
                    if (j_q == 2'd2) begin
                        j_d = '0;
                        if (i_q == 2'd2) begin
                            i_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            i_d = i_q + 2'd1;
                        end
                    end else begin
                        j_d = j_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_mantissa_mul_seq.sv
// Bench for mantissa_mul_seq: directed vectors plus a random phase.
// A transaction-level model is checked against the outputs every cycle.
module tb_mantissa_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] a_i;
    logic [23:0] b_i;
    logic        in_ready;
    logic        out_valid;
    logic        busy_o;
    logic [47:0] p_o;

    int total = 0;
    int bad   = 0;

    mantissa_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_o       (p_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one operation at a time, product ready
    // nine cycles after acceptance, held until taken.
    bit          m_pend;
    int          m_cnt;
    logic [47:0] m_exp;
    int          hs_cnt  = 0;
    int          acc_cnt = 0;
    bit          chk_en  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 1'b0;
            m_cnt  = 0;
        end else if (flush) begin
            m_pend = 1'b0;
        end else if (!m_pend) begin
            if (in_valid) begin
                m_pend = 1'b1;
                m_cnt  = 0;
                m_exp  = 48'(a_i) * 48'(b_i);
                acc_cnt++;
            end
        end else if (m_cnt < 9) begin
            m_cnt++;
        end else if (out_ready) begin
            m_pend = 1'b0;
            hs_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", 64'(in_ready), 64'(!m_pend));
            chk("m_out_valid", 64'(out_valid), 64'(m_pend && m_cnt == 9));
            chk("m_busy", 64'(busy_o), 64'(m_pend && m_cnt < 9));
            if (m_pend && m_cnt == 9)
                chk("m_p_o", 64'(p_o), 64'(m_exp));
            if (!m_pend)
                chk("m_p_idle", 64'(p_o), 64'd0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready)
            chk("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // lat counts the accept edge as edge 1
    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          input int hold, output logic [47:0] p,
                          output int lat);
        wait_ready();
        in_valid  = 1'b1;
        a_i       = a;
        b_i       = b;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            if (in_ready)
                chk("ready_in_mul", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid)
            chk("done_timeout", 64'(out_valid), 64'd1);
        p = p_o;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_p", 64'(p_o), 64'(p));
            chk("hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_ready", 64'(in_ready), 64'd1);
        chk("hs_valid", 64'(out_valid), 64'd0);
    endtask

    logic [47:0] p;
    int          lat;
    int          cyc;
    int          start;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        #2;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_p", 64'(p_o), 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op(24'hFFFFFF, 24'hFFFFFF, 0, p, lat);
        chk("max_p", 64'(p), 64'hFFFFFE000001);
        chk("max_lat", 64'(lat), 64'd10);

        run_op(24'h800000, 24'h800000, 0, p, lat);
        chk("msb_p", 64'(p), 64'h400000000000);
        run_op(24'h123456, 24'h000001, 0, p, lat);
        chk("one_p", 64'(p), 64'h000000123456);

        run_op(24'hC00000, 24'hA00000, 5, p, lat);
        chk("stall_p", 64'(p), 64'h780000000000);

        // abort during the fourth multiply cycle
        wait_ready();
        in_valid = 1'b1;
        a_i      = 24'hABCDEF;
        b_i      = 24'h13579B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_flush_busy", 64'(busy_o), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_p", 64'(p_o), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("flush_no_out", 64'(out_valid), 64'd0);
        run_op(24'h000002, 24'h000003, 0, p, lat);
        chk("after_flush_p", 64'(p), 64'h6);

        // asynchronous reset between edges
        wait_ready();
        in_valid = 1'b1;
        a_i      = 24'hABCDEF;
        b_i      = 24'h13579B;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_p", 64'(p_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(24'h000100, 24'h000100, 0, p, lat);
        chk("after_rst_p", 64'(p), 64'h10000);
        run_op(24'hABCDEF, 24'h13579B, 1, p, lat);
        chk("abc_p", 64'(p), 64'(48'hABCDEF * 48'h13579B));

        // random phase with stray in_valid, random back-pressure, rare flush
        cyc   = 0;
        start = hs_cnt;
        while (hs_cnt - start < 1000 && cyc < 40000) begin
            in_valid  = 1'($urandom_range(0, 1));
            a_i       = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            b_i       = ($urandom_range(0, 7) == 0) ? 24'h000000 : 24'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        chk("rand_count", 64'(hs_cnt - start >= 1000), 64'd1);
        chk("rand_no_dup", 64'(hs_cnt <= acc_cnt), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
